uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TO_CYCLES, 16, watchdog limit in clocks for tx_busy to rise after tx_start (used only when UART_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester level request; bit i held high until ack[i].
REQ-005 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-006 req_psel  input  4  per-requester parity select, forwarded to UART p_sel.
REQ-007 tx_busy  input  1  UART transmitter busy (frame in progress).
REQ-008 ack  output  4  one-hot, one-cycle pulse: byte of requester i latched.
REQ-009 tx_start  output  1  one-cycle start pulse to UART.
REQ-010 tx_data  output  8  byte to UART, stable from tx_start until return to IDLE.
REQ-011 tx_p_sel  output  1  parity select to UART, stable with tx_data.
REQ-012 owner  output  2  index of current/last granted requester.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: if req != 0, select winner, latch req_data slice into tx_data, req_psel bit into tx_p_sel, set owner, pulse ack[winner], go LAUNCH; else stay.
REQ-017 Arbitration SHALL be round-robin: search order owner+1, owner+2, owner+3, owner (mod 4); first set req bit wins.
REQ-018 LAUNCH: tx_start=1 for exactly this one cycle; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: on tx_busy=1 go WAIT_DONE; otherwise stay (see REQ-026).
REQ-020 WAIT_DONE: on tx_busy=0 go IDLE; next grant earliest in the IDLE cycle after.
REQ-021 Latency: req asserted in IDLE -> ack same-cycle-registered (visible next edge) -> tx_start one cycle after ack.
REQ-022 req changes outside IDLE SHALL be ignored; no ack issued outside IDLE.
REQ-023 Simultaneous req from all four with owner=3 SHALL grant 0,1,2,3 in that order on successive frames.
REQ-024 tx_busy already high on entry to WAIT_BUSY SHALL advance to WAIT_DONE on that cycle.

Reset
REQ-025 On rst_n=0 (any state, mid-frame included): state=IDLE, owner=3, ack=0, tx_start=0, tx_data=8'h00, tx_p_sel=0, busy=0, timeout_err=0, watchdog counter=0; no ack or tx_start for the interrupted transfer after release.

Configuration
REQ-026 Macro UART_ARB_TIMEOUT_EN defined: counter clears on LAUNCH, increments each WAIT_BUSY cycle with tx_busy=0; reaching TO_CYCLES pulses timeout_err and returns to IDLE, owner retained.
REQ-027 Macro undefined: no counter, WAIT_BUSY waits indefinitely, timeout_err tied 0.

Verification
REQ-028 Reset: rst_n=0 asserted mid-WAIT_DONE -> all outputs at REQ-025 values immediately, IDLE after release.
REQ-029 Single: req=4'b0100, req_data[23:16]=8'hA5, req_psel=4'b0100 -> ack=4'b0100, then tx_start pulse with tx_data=8'hA5, tx_p_sel=1, owner=2.
REQ-030 Round-robin: req=4'b1111 held (each bit dropped on its ack, re-raised) with UART model busy 10 cycles -> grant order 0,1,2,3,0.
REQ-031 Handshake: tx_busy rises 3 cycles after tx_start, falls 20 later -> busy high throughout, no second tx_start until after tx_busy falls.
REQ-032 Timeout (macro on): tx_busy held 0 after tx_start -> timeout_err pulse after 16 WAIT_BUSY cycles, state IDLE, next req granted.
REQ-033 Mid-transfer request: req=4'b0010 raised during WAIT_DONE of requester 0 -> no ack until IDLE, then ack=4'b0010.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Request-side and UART-side signal bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport; requesters and the UART model use master.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_psel;
    logic        tx_busy;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_p_sel;
    logic [1:0]  owner;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  req, req_data, req_psel, tx_busy,
        output ack, tx_start, tx_data, tx_p_sel, owner, busy, timeout_err
    );

    modport master (
        output req, req_data, req_psel, tx_busy,
        input  ack, tx_start, tx_data, tx_p_sel, owner, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter.
// Define UART_ARB_TIMEOUT_EN to build in the tx_busy watchdog (TO_CYCLES clocks).
//
// state     | meaning
// IDLE      | waiting for any req; grants, latches byte, pulses ack
// LAUNCH    | issues the registered tx_start pulse
// WAIT_BUSY | waiting for the UART to raise tx_busy
// WAIT_DONE | frame in progress, waiting for tx_busy to fall
module uart_tx_arbiter #(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ack_q, ack_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_p_sel_q, tx_p_sel_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  winner;
    logic        found;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
`else
    localparam bit unused_to_cycles = (TO_CYCLES != 0);
`endif

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        winner = owner_q;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && bus.req[owner_q + 2'(i)]) begin
                winner = owner_q + 2'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_p_sel_d = tx_p_sel_q;
        owner_d    = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    ack_d      = 4'b0001 << winner;
                    tx_data_d  = bus.req_data[{winner, 3'b000} +: 8];
                    tx_p_sel_d = bus.req_psel[winner];
                    owner_d    = winner;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                state_d    = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q + CNT_W'(1) == CNT_W'(TO_CYCLES)) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_p_sel_q <= 1'b0;
            owner_q    <= 2'd3;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_p_sel_q <= tx_p_sel_d;
            owner_q    <= owner_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_p_sel = tx_p_sel_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round-robin order,
// UART handshake, requests arriving mid-frame and the optional watchdog.
module tb_uart_tx_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TO_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] rst_vec;
        bus.req = 4'b0000; bus.req_data = 32'h0; bus.req_psel = 4'b0000; bus.tx_busy = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_vec = {4'b0000, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 1'b0};
        checks++;
        if ({bus.ack, bus.tx_start, bus.tx_data, bus.tx_p_sel, bus.owner, bus.busy, bus.timeout_err} !== rst_vec) begin
            errors++;
            $display("FAIL por_outputs got %h want %h",
                     {bus.ack, bus.tx_start, bus.tx_data, bus.tx_p_sel, bus.owner, bus.busy, bus.timeout_err}, rst_vec);
        end
        rst_n = 1'b1;
        tick();
        bus.req = 4'b0010; bus.req_data[15:8] = 8'h3C; bus.req_psel = 4'b0010;
        tick();
        checks++;
        if (bus.ack !== 4'b0010 || bus.owner !== 2'd1) begin
            errors++; $display("FAIL rst_pre_ack got ack=%b owner=%0d want ack=0010 owner=1", bus.ack, bus.owner);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h3C) begin
            errors++; $display("FAIL rst_pre_start got start=%b data=%h want start=1 data=3c", bus.tx_start, bus.tx_data);
        end
        bus.tx_busy = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre_busy got %b want 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ack, bus.tx_start, bus.tx_data, bus.tx_p_sel, bus.owner, bus.busy, bus.timeout_err} !== rst_vec) begin
            errors++;
            $display("FAIL midframe_reset got %h want %h",
                     {bus.ack, bus.tx_start, bus.tx_data, bus.tx_p_sel, bus.owner, bus.busy, bus.timeout_err}, rst_vec);
        end
        bus.tx_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (bus.ack !== 4'b0000 || bus.tx_start !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle got ack=%b start=%b busy=%b want 0000/0/0", bus.ack, bus.tx_start, bus.busy);
            end
        end
    endtask

    task automatic test_single();
        bus.req = 4'b0100; bus.req_data[23:16] = 8'hA5; bus.req_psel = 4'b0100;
        tick();
        checks++;
        if (bus.ack !== 4'b0100 || bus.tx_start !== 1'b0) begin
            errors++; $display("FAIL single_ack got ack=%b start=%b want 0100/0", bus.ack, bus.tx_start);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5 || bus.tx_p_sel !== 1'b1 ||
            bus.owner !== 2'd2 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_start got start=%b data=%h psel=%b owner=%0d ack=%b want 1/a5/1/2/0000",
                     bus.tx_start, bus.tx_data, bus.tx_p_sel, bus.owner, bus.ack);
        end
        bus.tx_busy = 1'b1;
        tick();
        checks++;
        if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'hA5 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_frame got start=%b data=%h busy=%b want 0/a5/1", bus.tx_start, bus.tx_data, bus.busy);
        end
        tick();
        bus.tx_busy = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_done got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        bus.req = 4'b1111; bus.req_data = 32'h44332211; bus.req_psel = 4'b1010;
        for (int f = 0; f < 5; f++) begin
            logic [1:0] w;
            logic [7:0] eb;
            w  = 2'(f % 4);
            eb = 8'((f % 4 + 1) * 17);
            tick();
            checks++;
            if (bus.ack !== (4'b0001 << w) || bus.owner !== w) begin
                errors++;
                $display("FAIL rr_grant%0d got ack=%b owner=%0d want ack=%b owner=%0d", f, bus.ack, bus.owner, 4'b0001 << w, w);
            end
            bus.req[w] = 1'b0;
            tick();
            checks++;
            if (bus.tx_start !== 1'b1 || bus.tx_data !== eb || bus.tx_p_sel !== w[0]) begin
                errors++;
                $display("FAIL rr_start%0d got start=%b data=%h psel=%b want 1/%h/%b", f, bus.tx_start, bus.tx_data, bus.tx_p_sel, eb, w[0]);
            end
            bus.req[w] = 1'b1;
            bus.tx_busy = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick();
                checks++;
                if (bus.ack !== 4'b0000 || bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_frame%0d_c%0d got ack=%b start=%b busy=%b want 0000/0/1", f, c, bus.ack, bus.tx_start, bus.busy);
                end
            end
            bus.tx_busy = 1'b0;
            tick();
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL rr_idle%0d got busy=%b want 0", f, bus.busy);
            end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_handshake();
        bus.req = 4'b1000;
        tick();
        checks++;
        if (bus.ack !== 4'b1000 || bus.owner !== 2'd3) begin
            errors++; $display("FAIL hs_ack got ack=%b owner=%0d want 1000/3", bus.ack, bus.owner);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h44 || bus.tx_p_sel !== 1'b1) begin
            errors++;
            $display("FAIL hs_start got start=%b data=%h psel=%b want 1/44/1", bus.tx_start, bus.tx_data, bus.tx_p_sel);
        end
        bus.req = 4'b0100;
        for (int c = 0; c < 22; c++) begin
            if (c == 2) bus.tx_busy = 1'b1;
            tick();
            checks++;
            if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0 || bus.ack !== 4'b0000) begin
                errors++;
                $display("FAIL hs_frame_c%0d got busy=%b start=%b ack=%b want 1/0/0000", c, bus.busy, bus.tx_start, bus.ack);
            end
        end
        bus.tx_busy = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== 4'b0000 || bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL hs_idle got busy=%b ack=%b start=%b want 0/0000/0", bus.busy, bus.ack, bus.tx_start);
        end
        tick();
        checks++;
        if (bus.ack !== 4'b0100 || bus.owner !== 2'd2) begin
            errors++; $display("FAIL hs_next_ack got ack=%b owner=%0d want 0100/2", bus.ack, bus.owner);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h33) begin
            errors++; $display("FAIL hs_next_start got start=%b data=%h want 1/33", bus.tx_start, bus.tx_data);
        end
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_mid_transfer();
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.ack !== 4'b0001 || bus.owner !== 2'd0) begin
            errors++; $display("FAIL mid_ack0 got ack=%b owner=%0d want 0001/0", bus.ack, bus.owner);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h11 || bus.tx_p_sel !== 1'b0) begin
            errors++;
            $display("FAIL mid_start0 got start=%b data=%h psel=%b want 1/11/0", bus.tx_start, bus.tx_data, bus.tx_p_sel);
        end
        bus.tx_busy = 1'b1;
        tick();
        bus.req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.ack !== 4'b0000) begin
                errors++; $display("FAIL mid_noack_c%0d got ack=%b want 0000", c, bus.ack);
            end
        end
        bus.tx_busy = 1'b0;
        tick();
        checks++;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_idle got ack=%b busy=%b want 0000/0", bus.ack, bus.busy);
        end
        tick();
        checks++;
        if (bus.ack !== 4'b0010 || bus.owner !== 2'd1) begin
            errors++; $display("FAIL mid_ack1 got ack=%b owner=%0d want 0010/1", bus.ack, bus.owner);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h22 || bus.tx_p_sel !== 1'b1) begin
            errors++;
            $display("FAIL mid_start1 got start=%b data=%h psel=%b want 1/22/1", bus.tx_start, bus.tx_data, bus.tx_p_sel);
        end
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.ack !== 4'b0100) begin
            errors++; $display("FAIL to_ack got ack=%b want 0100", bus.ack);
        end
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1001;
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
                errors++;
                $display("FAIL to_wait_c%0d got err=%b busy=%b ack=%b want 0/1/0000", c, bus.timeout_err, bus.busy, bus.ack);
            end
        end
        tick();
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0 || bus.owner !== 2'd2) begin
            errors++;
            $display("FAIL to_expire got err=%b busy=%b owner=%0d want 1/0/2", bus.timeout_err, bus.busy, bus.owner);
        end
        tick();
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.ack !== 4'b1000 || bus.owner !== 2'd3) begin
            errors++;
            $display("FAIL to_regrant got err=%b ack=%b owner=%0d want 0/1000/3", bus.timeout_err, bus.ack, bus.owner);
        end
        bus.req = 4'b0000;
        tick();
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        tick();
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++;
            if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
                errors++;
                $display("FAIL nto_wait_c%0d got err=%b busy=%b ack=%b want 0/1/0000", c, bus.timeout_err, bus.busy, bus.ack);
            end
        end
        bus.req = 4'b0000;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.owner !== 2'd3) begin
            errors++; $display("FAIL nto_recover got busy=%b owner=%0d want 0/3", bus.busy, bus.owner);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_handshake();
        test_mid_transfer();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
